// File: rtl/fact_seq_pkg.sv
// Shared widths, limits and state encoding for the factorial sequencer.
package fact_seq_pkg;

  localparam int N_W       = 6;
  localparam int R_W       = 64;
  localparam int MUL_STEPS = 6;

  // Largest n whose factorial fits in R_W bits.
  localparam logic [N_W-1:0] OVF_N = 6'd20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NEXT = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/fact_seq_if.sv
// Request/result bundle between a requester and the factorial sequencer.
interface fact_seq_if;
  import fact_seq_pkg::*;

  logic           start;
  logic [N_W-1:0] n_in;
  logic           busy;
  logic           done;
  logic [R_W-1:0] result;
  logic           overflow;

  modport master (output start, n_in, input busy, done, result, overflow);
  modport slave  (input start, n_in, output busy, done, result, overflow);

endinterface

// File: rtl/fact_cnt_dn.sv
// Loadable down-counter holding the current multiplier, with a "equals two" flag.
module fact_cnt_dn
  import fact_seq_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  input  logic           load_i,
  input  logic           dec_i,
  input  logic [N_W-1:0] d_i,
  output logic [N_W-1:0] q_o,
  output logic           is_two_o
);

  logic [N_W-1:0] cnt_q;

  // Counter register; load wins over decrement.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 6'd0;
    end else if (load_i) begin
      cnt_q <= d_i;
    end else if (dec_i) begin
      cnt_q <= cnt_q - 6'd1;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign q_o      = cnt_q;
  assign is_two_o = (cnt_q == 6'd2);

endmodule

// File: rtl/fact_seq.sv
// Iterative factorial: acc is multiplied by cnt, cnt-1, ..., 2 with a
// bit-serial shift-add multiply (one multiplier bit per cycle).
module fact_seq
  import fact_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  fact_seq_if.slave  bus
);

  localparam logic [2:0] LAST_BIT = 3'(MUL_STEPS - 1);

  state_t         state_q, state_d;
  logic [R_W-1:0] acc_q, acc_d;
  logic [R_W-1:0] tmp_q, tmp_d;
  logic [2:0]     bidx_q, bidx_d;
  logic           ovf_pend_q, ovf_pend_d;
  logic [R_W-1:0] result_q, result_d;
  logic           overflow_q, overflow_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           cnt_load_s;
  logic           cnt_dec_s;
  logic [N_W-1:0] cnt_s;
  logic           cnt_is_two_s;

  fact_cnt_dn u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_i   (cnt_load_s),
    .dec_i    (cnt_dec_s),
    .d_i      (bus.n_in),
    .q_o      (cnt_s),
    .is_two_o (cnt_is_two_s)
  );

  // Next-state, datapath next values and counter enables.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    tmp_d      = tmp_q;
    bidx_d     = bidx_q;
    ovf_pend_d = ovf_pend_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    cnt_load_s = 1'b0;
    cnt_dec_s  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          cnt_load_s = 1'b1;
          acc_d      = 64'd1;
          tmp_d      = 64'd0;
          bidx_d     = 3'd0;
          ovf_pend_d = (bus.n_in > OVF_N);
          if (bus.n_in <= 6'd1) begin
            // 0! and 1! skip the multiply and report 1 in the DONE cycle.
            state_d    = DONE;
            result_d   = 64'd1;
            overflow_d = (bus.n_in > OVF_N);
          end else begin
            state_d = MUL;
          end
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        if (cnt_s[bidx_q]) begin
          tmp_d = tmp_q + (acc_q << bidx_q);
        end else begin
          tmp_d = tmp_q;
        end
        if (bidx_q == LAST_BIT) begin
          bidx_d  = 3'd0;
          state_d = NEXT;
        end else begin
          bidx_d  = bidx_q + 3'd1;
          state_d = MUL;
        end
      end
      NEXT: begin
        acc_d = tmp_q;
        tmp_d = 64'd0;
        if (cnt_is_two_s) begin
          // acc is being loaded with tmp on this edge, so publish tmp directly.
          state_d    = DONE;
          result_d   = tmp_q;
          overflow_d = ovf_pend_q;
        end else begin
          cnt_dec_s = 1'b1;
          state_d   = MUL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == MUL) || (state_d == NEXT);
    done_d = (state_d == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      acc_q      <= 64'd0;
      tmp_q      <= 64'd0;
      bidx_q     <= 3'd0;
      ovf_pend_q <= 1'b0;
      result_q   <= 64'd0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      tmp_q      <= tmp_d;
      bidx_q     <= bidx_d;
      ovf_pend_q <= ovf_pend_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_fact_seq.sv
// Directed bench for fact_seq: latency, results, overflow flag, ignored starts and reset.
module tb_fact_seq;
  import fact_seq_pkg::*;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_pass;

  fact_seq_if bus ();

  fact_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] fact_ref(input int n);
    logic [63:0] f;
    f = 64'd1;
    for (int i = 2; i <= n; i++) f = f * 64'(i);
    return f;
  endfunction

  // Issue one request from the current cycle (cycle 0) and follow it to its done pulse.
  // ign > 0 pulses a competing start (n=7) in that cycle; it must be ignored.
  task automatic run_op(input string tag, input logic [5:0] n, input logic [63:0] exp_res,
                        input logic exp_ovf, input int exp_cyc, input int ign);
    int          cyc;
    int          bad_busy;
    int          bad_hold;
    logic [63:0] prev_res;
    logic        prev_ovf;
    prev_res = bus.result;
    prev_ovf = bus.overflow;
    bad_busy = 0;
    bad_hold = 0;
    bus.start = 1'b1;
    bus.n_in  = n;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 1000) begin
      bus.start = (cyc == ign);
      bus.n_in  = (cyc == ign) ? 6'd7 : n;
      if (bus.busy !== 1'b1) bad_busy++;
      if (bus.result !== prev_res || bus.overflow !== prev_ovf) bad_hold++;
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    check_val({tag, " done_cycle"}, 64'(cyc), 64'(exp_cyc));
    check_val({tag, " result"}, bus.result, exp_res);
    check_val({tag, " overflow"}, 64'(bus.overflow), 64'(exp_ovf));
    check_val({tag, " busy_in_done"}, 64'(bus.busy), 64'd0);
    check_val({tag, " busy_gaps"}, 64'(bad_busy), 64'd0);
    check_val({tag, " hold_while_busy"}, 64'(bad_hold), 64'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.n_in  = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst busy", 64'(bus.busy), 64'd0);
    check_val("rst done", 64'(bus.done), 64'd0);
    check_val("rst result", bus.result, 64'd0);
    check_val("rst overflow", 64'(bus.overflow), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // n=0 then n=1 re-accepted in the DONE cycle
    run_op("n0", 6'd0, 64'd1, 1'b0, 1, 0);
    run_op("n1", 6'd1, 64'd1, 1'b0, 1, 0);
    @(posedge clk); #1;
    check_val("n1 done_pulse_width", 64'(bus.done), 64'd0);

    run_op("n5", 6'd5, 64'd120, 1'b0, 29, 10);
    @(posedge clk); #1;
    check_val("n5 done_pulse_width", 64'(bus.done), 64'd0);
    check_val("n5 idle_busy", 64'(bus.busy), 64'd0);

    run_op("n20", 6'd20, 64'd2432902008176640000, 1'b0, 134, 0);
    run_op("n21", 6'd21, 64'd14197454024290336768, 1'b1, 141, 0);
    run_op("n2", 6'd2, 64'd2, 1'b0, 8, 0);
    run_op("n63", 6'd63, fact_ref(63), 1'b1, 435, 0);
    check_val("n63 ref_nonzero_sanity", 64'(fact_ref(5)), 64'd120);

    // Reset in the middle of an n=10 computation
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.n_in  = 6'd10;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    check_val("mid busy_before_reset", 64'(bus.busy), 64'd1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_val("mid rst busy", 64'(bus.busy), 64'd0);
    check_val("mid rst done", 64'(bus.done), 64'd0);
    check_val("mid rst result", bus.result, 64'd0);
    check_val("mid rst overflow", 64'(bus.overflow), 64'd0);
    @(posedge clk); #1;
    check_val("mid rst busy_held", 64'(bus.busy), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_op("post_rst n3", 6'd3, 64'd6, 1'b0, 15, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
